// File: rtl/shift_exec_stage.sv
// Execute-stage shift wrapper: 16-bit shifter on the input side feeding a
// 2-entry skid buffer (head + skid) with valid/ready handshakes on both ends.
module shift_exec_stage #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_opnd,
  input  logic [15:0]      in_regcnt,
  input  logic [3:0]       in_imm,
  input  logic             in_use_imm,
  input  logic [1:0]       in_shop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [15:0]      head_res_q, skid_res_q;
  logic             head_zero_q, skid_zero_q;
  logic [TAG_W-1:0] head_tag_q, skid_tag_q;

  logic [3:0]  cnt;
  logic [15:0] shift_res;
  logic [31:0] dbl_l, dbl_r;
  logic        accept, pop;
  logic        load_head_new, load_head_skid, load_skid;

  // Shifter: rotates take the wrapped half of a doubled operand.
  assign cnt   = in_use_imm ? in_imm : in_regcnt[3:0];
  assign dbl_l = {in_opnd, in_opnd} << cnt;
  assign dbl_r = {in_opnd, in_opnd} >> cnt;

  always_comb begin
    shift_res = in_opnd;
    unique case (in_shop)
      2'b00: shift_res = dbl_l[31:16];
      2'b01: shift_res = in_opnd << cnt;
      2'b10: shift_res = dbl_r[15:0];
      2'b11: shift_res = in_opnd >> cnt;
      default: shift_res = in_opnd;
    endcase
  end

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = (state_q != StEmpty) & out_ready & ~flush;

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d       = StOne;
            load_head_new = 1'b1;
          end
        end
        StOne: begin
          if (accept && pop) begin
            load_head_new = 1'b1;
          end else if (accept) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d        = StOne;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      head_res_q  <= '0;
      head_zero_q <= 1'b0;
      head_tag_q  <= '0;
      skid_res_q  <= '0;
      skid_zero_q <= 1'b0;
      skid_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
      if (load_head_new) begin
        head_res_q  <= shift_res;
        head_zero_q <= (shift_res == 16'h0000);
        head_tag_q  <= in_tag;
      end else if (load_head_skid) begin
        head_res_q  <= skid_res_q;
        head_zero_q <= skid_zero_q;
        head_tag_q  <= skid_tag_q;
      end
      if (load_skid) begin
        skid_res_q  <= shift_res;
        skid_zero_q <= (shift_res == 16'h0000);
        skid_tag_q  <= in_tag;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != StEmpty);
  assign out_result = head_res_q;
  assign out_zero   = head_zero_q;
  assign out_tag    = head_tag_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed-vector bench for shift_exec_stage: shift ops, skid ordering,
// flush and asynchronous reset.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_use_imm, out_valid, out_ready, out_zero;
  logic [15:0] in_opnd, in_regcnt, out_result;
  logic [3:0]  in_imm;
  logic [1:0]  in_shop;
  logic [2:0]  in_tag, out_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_exec_stage #(.TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opnd(in_opnd),
    .in_regcnt(in_regcnt), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_shop(in_shop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] opnd, input logic [15:0] regcnt,
                       input logic [3:0] imm, input logic use_imm,
                       input logic [1:0] shop, input logic [2:0] tag);
    in_valid   = 1'b1;
    in_opnd    = opnd;
    in_regcnt  = regcnt;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_shop    = shop;
    in_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opnd = '0; in_regcnt = '0; in_imm = '0; in_use_imm = 1'b0; in_shop = '0; in_tag = '0;
    tick(); tick();
    checks++;
    if ({out_valid, in_ready, out_result, out_zero, out_tag} !== {1'b0, 1'b1, 16'h0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b res=%h zero=%b tag=%0d, want 0 1 0000 0 0",
               out_valid, in_ready, out_result, out_zero, out_tag);
    end
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [15:0] opnd;
    logic [15:0] regcnt;
    logic [3:0]  imm;
    logic        use_imm;
    logic [1:0]  shop;
    logic [2:0]  tag;
    logic [15:0] exp;
    logic        zero;
  } vec_t;

  task automatic test_shift();
    vec_t v[8];
    v[0] = '{16'h0001, 16'h0000, 4'd15, 1'b1, 2'b01, 3'd1, 16'h8000, 1'b0};
    v[1] = '{16'h8001, 16'hFFF1, 4'd7,  1'b0, 2'b10, 3'd2, 16'hC000, 1'b0};
    v[2] = '{16'h1234, 16'h0000, 4'd4,  1'b1, 2'b00, 3'd3, 16'h2341, 1'b0};
    v[3] = '{16'h1234, 16'h0005, 4'd0,  1'b1, 2'b00, 3'd4, 16'h1234, 1'b0};
    v[4] = '{16'h0001, 16'h0000, 4'd1,  1'b1, 2'b11, 3'd5, 16'h0000, 1'b1};
    v[5] = '{16'h8000, 16'h000F, 4'd3,  1'b0, 2'b11, 3'd6, 16'h0001, 1'b0};
    v[6] = '{16'h1234, 16'h0000, 4'd4,  1'b1, 2'b10, 3'd7, 16'h4123, 1'b0};
    v[7] = '{16'h1234, 16'h0000, 4'd4,  1'b1, 2'b01, 3'd0, 16'h2340, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(v[i].opnd, v[i].regcnt, v[i].imm, v[i].use_imm, v[i].shop, v[i].tag);
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_result, out_zero, out_tag} !== {1'b1, v[i].exp, v[i].zero, v[i].tag}) begin
        failures++;
        $display("FAIL shift[%0d]: valid=%b res=%h zero=%b tag=%0d, want 1 %h %b %0d", i,
                 out_valid, out_result, out_zero, out_tag, v[i].exp, v[i].zero, v[i].tag);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL shift_pop[%0d]: valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(16'h00A1, 16'h0, 4'd0, 1'b1, 2'b01, 3'd1);
    tick();
    checks++;
    if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b1, 16'h00A1, 3'd1}) begin
      failures++;
      $display("FAIL b2b_a: ready=%b valid=%b res=%h tag=%0d, want 1 1 00a1 1",
               in_ready, out_valid, out_result, out_tag);
    end
    drive(16'h00B2, 16'h0, 4'd0, 1'b1, 2'b01, 3'd2);
    tick();
    checks++;
    if ({in_ready, out_result, out_tag} !== {1'b0, 16'h00A1, 3'd1}) begin
      failures++;
      $display("FAIL b2b_full: ready=%b res=%h tag=%0d, want 0 00a1 1", in_ready, out_result, out_tag);
    end
    drive(16'h00C3, 16'h0, 4'd0, 1'b1, 2'b01, 3'd3);
    tick();
    checks++;
    if ({in_ready, out_valid, out_result, out_tag} !== {1'b0, 1'b1, 16'h00A1, 3'd1}) begin
      failures++;
      $display("FAIL b2b_hold: ready=%b valid=%b res=%h tag=%0d, want 0 1 00a1 1",
               in_ready, out_valid, out_result, out_tag);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b1, 16'h00B2, 3'd2}) begin
      failures++;
      $display("FAIL b2b_pop_a: ready=%b valid=%b res=%h tag=%0d, want 1 1 00b2 2",
               in_ready, out_valid, out_result, out_tag);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_result, out_tag} !== {1'b1, 1'b1, 16'h00C3, 3'd3}) begin
      failures++;
      $display("FAIL b2b_pop_b: ready=%b valid=%b res=%h tag=%0d, want 1 1 00c3 3",
               in_ready, out_valid, out_result, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(16'h0011, 16'h0, 4'd0, 1'b1, 2'b01, 3'd4);
    tick();
    drive(16'h0022, 16'h0, 4'd0, 1'b1, 2'b01, 3'd5);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_fill: ready=%b, want 0", in_ready);
    end
    drive(16'h0033, 16'h0, 4'd0, 1'b1, 2'b01, 3'd6);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flush: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_lost: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(16'h00F0, 16'h0, 4'd0, 1'b1, 2'b01, 3'd7);
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, out_result, out_zero, out_tag} !== {1'b0, 1'b1, 16'h0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_mid: valid=%b ready=%b res=%h zero=%b tag=%0d, want 0 1 0000 0 0",
               out_valid, in_ready, out_result, out_zero, out_tag);
    end
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    drive(16'h0F00, 16'h0, 4'd4, 1'b1, 2'b11, 3'd2);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_result, out_tag} !== {1'b1, 16'h00F0, 3'd2}) begin
      failures++;
      $display("FAIL reset_restart: valid=%b res=%h tag=%0d, want 1 00f0 2",
               out_valid, out_result, out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
